keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the board's multiplexed 7-segment display path.
- Scans a 4x4 matrix keypad by driving rows one at a time and sampling the columns, then debounces the result.
- Reports each press as a 4-bit key code with a one-cycle valid strobe.
- Shifts accepted codes into a 32-bit KeyData register, so the board top can feed KeyData straight to the display driver or to CPU memory-mapped I/O.

Parameters:
- SCAN_DIV, 5000, clock cycles each row is driven per scan step; must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; must be >= 1.
- REPEAT_DELAY, 64, full scans a key is held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 16, full scans between later auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- COL  in  4  keypad columns, active-low, asynchronous to CLK.
- clr_data  in  1  synchronous clear of KeyData.
- ROW  out  4  keypad row drive, one-hot active-low.
- key_code  out  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-cycle strobe; key_code is valid in that cycle.
- key_held  out  1  high while an accepted key remains pressed.
- KeyData  out  32  shift register of accepted codes, newest in bits [3:0].

Behaviour:
- Reset values:
  - ROW=4'b1110, row_idx=0, dwell counter=0, state IDLE.
  - key_code=0, key_valid=0, key_held=0, KeyData=0.
  - Debounce and repeat counters 0; synchronizer flops 4'b1111.
- Column synchronizer: COL passes through a 2-flop synchronizer before use.
- Row dwell:
  - Each row is driven for SCAN_DIV cycles.
  - On dwell count SCAN_DIV-1, the synchronized columns are sampled into a 16-bit scan image at bits [row_idx*4 +: 4] (stored inverted, so 1 = pressed).
  - row_idx then advances 0->1->2->3->0 and ROW updates on the same edge.
- Scan end: the sample cycle of row 3. One full scan takes 4*SCAN_DIV cycles.
- Scan classification at scan end:
  - NONE: zero bits set.
  - SINGLE(c): exactly one bit set; c = row*4 + col.
  - MULTI: two or more bits set. Treated as NONE for acceptance; it does not reset an active HELD key.
- FSM, evaluated only at scan end:
  - IDLE:
    - SINGLE(c): cand=c, cnt=1, go to DEBOUNCE. If DEBOUNCE_SCANS=1, accept immediately instead.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Accept, in the cycle after scan end:
    - key_code=cand, key_valid=1 for 1 cycle, key_held=1.
    - KeyData = {KeyData[27:0], cand}.
  - HELD:
    - SINGLE(cand) or MULTI: stay.
    - NONE: rcnt=1, go to RELEASE.
    - SINGLE(other): go to RELEASE with rcnt=1.
  - RELEASE:
    - NONE: rcnt++. When rcnt reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
    - SINGLE(cand): return to HELD with no new strobe.
    - SINGLE(other) or MULTI: rcnt=1, stay.
- Latency: key_valid rises 1 cycle after the scan end of the DEBOUNCE_SCANS-th consecutive matching scan.
- clr_data:
  - Sets KeyData to 0 next cycle.
  - If clr_data and an accept occur in the same cycle, KeyData = {28'h0, cand}.
  - Does not affect the FSM.
- KeyData wrap: after 8 accepts, the oldest nibble falls off bits [31:28].
- RST mid-operation: everything returns to reset values. A key still pressed is re-debounced and produces a fresh strobe.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a scan counter counts matching scans.
  - After REPEAT_DELAY scans, key_valid pulses again with the same key_code and KeyData shifts it in again.
  - Further repeats follow every REPEAT_RATE scans.
  - The counter resets on entry to HELD and on leaving HELD.
- Undefined: exactly one key_valid per press; repeat counters and parameters are unused.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3; hold row1/col2 for 10 scans -> one key_valid pulse at cycle 3*16+1 after press alignment (plus synchronizer), key_code=4'h6, KeyData=32'h00000006, key_held=1 until 3 NONE scans after release.
- Column toggles every 5 cycles for 200 cycles -> key_valid never asserted, KeyData stays 0.
- Keys row0/col1 and row2/col3 pressed together from IDLE -> no strobe. Release row2/col3 -> key_code=4'h1 accepted after 3 scans.
- Press/release codes 1, 2, 3 in sequence -> KeyData=32'h00000123. Pulse clr_data -> 0. Nine presses of 4'hA -> KeyData=32'hAAAAAAAA.
- RST asserted while HELD with key 4'h5 still pressed -> next cycle ROW=4'b1110 and all outputs 0. After 3 scans, a new strobe appears with key_code=4'h5.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=2; hold key 4'hF for 20 scans -> strobes at accept, then +8 scans, then every 2 scans. Without the macro -> exactly 1 strobe.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the key report outputs.
// The scanner uses the master modport; the board side or a testbench uses slave.
interface keypad_scanner_if;
  logic [3:0]  COL;
  logic        clr_data;
  logic [3:0]  ROW;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] KeyData;

  modport master (
    input  COL,
    input  clr_data,
    output ROW,
    output key_code,
    output key_valid,
    output key_held,
    output KeyData
  );

  modport slave (
    output COL,
    output clr_data,
    input  ROW,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  KeyData
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce and a 32-bit shift register of key codes.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 64,
  parameter int unsigned REPEAT_RATE    = 16
) (
  input logic              CLK,
  input logic              RST,
  keypad_scanner_if.master kif
);

  localparam int unsigned DivW       = $clog2(SCAN_DIV);
  localparam int unsigned CntW       = $clog2(DEBOUNCE_SCANS + 1) + 1;
  localparam bit          SingleScan = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

  logic [3:0]      col_s1_q, col_s2_q;
  logic [DivW-1:0] dwell_q;
  logic [1:0]      row_idx_q;
  logic [11:0]     img_q;
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [31:0]     key_data_q, key_data_d;
  logic            sample, scan_end, deb_done, accept;
  logic [15:0]     scan;
  logic [1:0]      n_set;
  logic [3:0]      hit;
  logic            is_none, is_single;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic            rep_rate_q, rep_rate_d;
`endif

  assign sample   = (dwell_q == DivW'(SCAN_DIV - 1));
  assign scan_end = sample && (row_idx_q == 2'd3);
  // Row 3 is classified straight from the synchronizer on its own sample cycle.
  assign scan     = {~col_s2_q, img_q};
  assign cnt_inc  = cnt_q + CntW'(1);
  assign deb_done = (cnt_inc >= CntW'(DEBOUNCE_SCANS));

  always_comb begin
    n_set = 2'd0;
    hit   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan[i]) begin
        if (n_set == 2'd0) hit = 4'(i);
        if (n_set != 2'd2) n_set = n_set + 2'd1;
      end
    end
  end

  assign is_none   = (n_set == 2'd0);
  assign is_single = (n_set == 2'd1);

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    key_held_d = key_held_q;
    accept     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_rate_d = rep_rate_q;
    rep_inc    = rep_cnt_q + RepW'(1);
`endif
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_single) begin
            cand_d = hit;
            cnt_d  = CntW'(1);
            if (SingleScan) begin
              accept  = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (is_single && hit == cand_q) begin
            cnt_d = cnt_inc;
            if (deb_done) begin
              accept  = 1'b1;
              state_d = StHeld;
            end
          end else if (is_single) begin
            cand_d = hit;
            cnt_d  = CntW'(1);
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (is_none || (is_single && hit != cand_q)) begin
            cnt_d = CntW'(1);
            if (SingleScan) begin
              key_held_d = 1'b0;
              state_d    = StIdle;
            end else begin
              state_d = StRelease;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (is_single) begin
            if (rep_inc >= (rep_rate_q ? RepW'(REPEAT_RATE) : RepW'(REPEAT_DELAY))) begin
              accept     = 1'b1;
              rep_cnt_d  = '0;
              rep_rate_d = 1'b1;
            end else begin
              rep_cnt_d = rep_inc;
            end
          end
`endif
        end
        StRelease: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (deb_done) begin
              key_held_d = 1'b0;
              state_d    = StIdle;
            end
          end else if (is_single && hit == cand_q) begin
            state_d = StHeld;
          end else begin
            cnt_d = CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_q != StHeld || state_d != StHeld) begin
      rep_cnt_d  = '0;
      rep_rate_d = 1'b0;
    end
`endif
    if (accept) key_held_d = 1'b1;
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    key_data_d  = key_data_q;
    if (accept) key_data_d = {key_data_q[27:0], cand_d};
    if (kif.clr_data) key_data_d = accept ? {28'h0, cand_d} : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      dwell_q     <= '0;
      row_idx_q   <= 2'd0;
      img_q       <= '0;
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      key_data_q  <= 32'h0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_rate_q  <= 1'b0;
`endif
    end else begin
      col_s1_q <= kif.COL;
      col_s2_q <= col_s1_q;
      if (sample) begin
        dwell_q   <= '0;
        row_idx_q <= row_idx_q + 2'd1;
        unique case (row_idx_q)
          2'd0:    img_q[3:0]  <= ~col_s2_q;
          2'd1:    img_q[7:4]  <= ~col_s2_q;
          2'd2:    img_q[11:8] <= ~col_s2_q;
          default: ;
        endcase
      end else begin
        dwell_q <= dwell_q + DivW'(1);
      end
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      key_data_q  <= key_data_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_rate_q  <= rep_rate_d;
`endif
    end
  end

  assign kif.ROW       = ~(4'b0001 << row_idx_q);
  assign kif.key_code  = key_code_q;
  assign kif.key_valid = key_valid_q;
  assign kif.key_held  = key_held_q;
  assign kif.KeyData   = key_data_q;

endmodule
